// File: rtl/shift_arbiter.sv
// Two-port arbiter in front of a shared combinational barrel shifter.
// Port 0 (ALU) has priority; port 1 (mul/div sequencer) is starvation-guarded and its result can be held.
module shift_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [4:0]  req0_shamt,
  input  logic [4:0]  req0_type,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [4:0]  req1_shamt,
  input  logic [4:0]  req1_type,
  input  logic [3:0]  req1_tag,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_r,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_r,
  output logic [3:0]  rsp1_tag,
  output logic [31:0] sh_a,
  output logic [4:0]  sh_shamt,
  output logic [4:0]  sh_type,
  input  logic [31:0] sh_r
);

  typedef enum logic {IDLE, HOLD1} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      state, state_nxt;
  logic        stage_v, owner;
  logic [31:0] st_a;
  logic [4:0]  st_shamt, st_type;
  logic [3:0]  st_tag;
  logic [31:0] hold_r;
  logic [3:0]  hold_tag;
  logic [3:0]  starve_cnt;

  logic busy1, starve, grant0, grant1, stage1_v, capture;

  // Port 1 may have only one op in flight: either in the stage or parked in the hold regs.
  assign busy1    = (stage_v & owner) | (state == HOLD1);
  assign starve   = (starve_cnt == LIMIT);
  assign grant1   = req1_valid & ~busy1 & (~req0_valid | starve);
  assign grant0   = req0_valid & ~grant1;
  assign stage1_v = stage_v & owner;

  assign req0_ready = ~grant1;
  assign req1_ready = ~busy1 & (~req0_valid | starve);

  assign sh_a     = st_a;
  assign sh_shamt = st_shamt;
  assign sh_type  = st_type;

  assign rsp0_valid = stage_v & ~owner;
  assign rsp0_r     = sh_r;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt  = state;
    capture    = 1'b0;
    rsp1_valid = 1'b0;
    rsp1_r     = sh_r;
    rsp1_tag   = st_tag;
    case (state)
      IDLE: begin
        rsp1_valid = stage1_v;
        if (stage1_v && !rsp1_ready) begin
          capture   = 1'b1;
          state_nxt = HOLD1;
        end
      end
      HOLD1: begin
        rsp1_valid = 1'b1;
        rsp1_r     = hold_r;
        rsp1_tag   = hold_tag;
        if (rsp1_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      stage_v    <= 1'b0;
      owner      <= 1'b0;
      st_a       <= '0;
      st_shamt   <= '0;
      st_type    <= '0;
      st_tag     <= '0;
      hold_r     <= '0;
      hold_tag   <= '0;
      starve_cnt <= '0;
    end else begin
      state   <= state_nxt;
      stage_v <= grant0 | grant1;
      if (grant1) begin
        owner    <= 1'b1;
        st_a     <= req1_a;
        st_shamt <= req1_shamt;
        st_type  <= req1_type;
        st_tag   <= req1_tag;
      end else if (grant0) begin
        owner    <= 1'b0;
        st_a     <= req0_a;
        st_shamt <= req0_shamt;
        st_type  <= req0_type;
      end
      if (capture) begin
        hold_r   <= sh_r;
        hold_tag <= st_tag;
      end
      // Counts only cycles where port 1 could have gone but port 0 took the shifter.
      if (!req1_valid || grant1)
        starve_cnt <= '0;
      else if (!busy1 && !starve)
        starve_cnt <= starve_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: models the external shifter, scoreboards both response ports,
// and checks grants, backpressure, starvation override, concurrency and reset.
module tb_shift_arbiter;

  localparam logic [4:0] ALU_SLL  = 5'h01;
  localparam logic [4:0] ALU_SRL  = 5'h02;
  localparam logic [4:0] ALU_SRA  = 5'h03;
  localparam logic [4:0] ALU_SLLI = 5'h04;
  localparam logic [4:0] ALU_SRLI = 5'h05;
  localparam logic [4:0] ALU_SRAI = 5'h06;

  typedef struct {
    logic [31:0] r;
    logic [3:0]  tag;
  } rsp1_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready;
  logic [31:0] req0_a;
  logic [4:0]  req0_shamt, req0_type;
  logic        req1_valid, req1_ready;
  logic [31:0] req1_a;
  logic [4:0]  req1_shamt, req1_type;
  logic [3:0]  req1_tag;
  logic        rsp0_valid;
  logic [31:0] rsp0_r;
  logic        rsp1_valid, rsp1_ready;
  logic [31:0] rsp1_r;
  logic [3:0]  rsp1_tag;
  logic [31:0] sh_a;
  logic [4:0]  sh_shamt, sh_type;
  logic [31:0] sh_r;

  int errors = 0;
  int checks = 0;

  logic [31:0] q0[$];
  rsp1_t       q1[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] shift_model(logic [31:0] a, logic [4:0] sh, logic [4:0] t);
    case (t)
      ALU_SLL, ALU_SLLI: return a << sh;
      ALU_SRL, ALU_SRLI: return a >> sh;
      ALU_SRA, ALU_SRAI: return 32'($signed(a) >>> sh);
      default:           return 32'h0;
    endcase
  endfunction

  assign sh_r = shift_model(sh_a, sh_shamt, sh_type);

  shift_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_shamt(req0_shamt), .req0_type(req0_type),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_shamt(req1_shamt), .req1_type(req1_type), .req1_tag(req1_tag),
    .rsp0_valid(rsp0_valid), .rsp0_r(rsp0_r),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_r(rsp1_r), .rsp1_tag(rsp1_tag),
    .sh_a(sh_a), .sh_shamt(sh_shamt), .sh_type(sh_type), .sh_r(sh_r)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare DUT responses with the scoreboard; port 1 entries leave only on a completed handshake.
  task automatic observe();
    check("rsp0_valid", 32'(rsp0_valid), 32'(q0.size() > 0));
    if (q0.size() > 0) check("rsp0_r", rsp0_r, q0.pop_front());
    check("rsp1_valid", 32'(rsp1_valid), 32'(q1.size() > 0));
    if (q1.size() > 0) begin
      check("rsp1_r", rsp1_r, q1[0].r);
      check("rsp1_tag", 32'(rsp1_tag), 32'(q1[0].tag));
    end
  endtask

  // Inputs are driven at posedge+1; settle, record handshakes, clock, then observe at posedge+1.
  task automatic step();
    bit acc0, acc1, pop1, in_rst;
    rsp1_t e;
    #1;
    in_rst = rst;
    acc0 = !rst && req0_valid && req0_ready;
    acc1 = !rst && req1_valid && req1_ready;
    pop1 = rsp1_valid && rsp1_ready;
    @(posedge clk);
    #1;
    if (pop1 && q1.size() > 0) void'(q1.pop_front());
    if (in_rst) begin
      q0.delete();
      q1.delete();
    end
    if (acc0) q0.push_back(shift_model(req0_a, req0_shamt, req0_type));
    if (acc1) begin
      e.r   = shift_model(req1_a, req1_shamt, req1_type);
      e.tag = req1_tag;
      q1.push_back(e);
    end
    observe();
  endtask

  task automatic drive0(input logic v, input logic [31:0] a, input logic [4:0] sh, input logic [4:0] t);
    req0_valid = v; req0_a = a; req0_shamt = sh; req0_type = t;
  endtask

  task automatic drive1(input logic v, input logic [31:0] a, input logic [4:0] sh, input logic [4:0] t,
                        input logic [3:0] tag);
    req1_valid = v; req1_a = a; req1_shamt = sh; req1_type = t; req1_tag = tag;
  endtask

  initial begin
    rst = 1'b1;
    rsp1_ready = 1'b1;
    drive0(1'b0, 32'h0, 5'd0, 5'd0);
    drive1(1'b0, 32'h0, 5'd0, 5'd0, 4'h0);
    @(posedge clk); #1;
    step();
    check("reset_req0_ready", 32'(req0_ready), 32'd1);
    check("reset_req1_ready", 32'(req1_ready), 32'd1);
    check("reset_sh_type", 32'(sh_type), 32'd0);
    check("reset_sh_a", sh_a, 32'd0);
    rst = 1'b0;

    // Port 0 alone
    drive0(1'b1, 32'h8000_0000, 5'd4, ALU_SRA);
    step();
    check("p0_sra", rsp0_r, 32'hF800_0000);
    drive0(1'b1, 32'h8000_0000, 5'd4, ALU_SRL);
    step();
    check("p0_srl", rsp0_r, 32'h0800_0000);
    drive0(1'b0, 32'h0, 5'd0, 5'd0);
    step();

    // Port 1 alone, consumer stalls for 3 cycles
    rsp1_ready = 1'b0;
    drive1(1'b1, 32'h0000_0001, 5'd31, ALU_SLL, 4'hA);
    #1;
    check("p1_ready_idle", 32'(req1_ready), 32'd1);
    step();
    drive1(1'b0, 32'h0, 5'd0, 5'd0, 4'h0);
    for (int i = 0; i < 3; i++) begin
      check("bp_rsp1_r", rsp1_r, 32'h8000_0000);
      check("bp_rsp1_tag", 32'(rsp1_tag), 32'hA);
      check("bp_req1_ready", 32'(req1_ready), 32'd0);
      if (i < 2) step();
    end
    rsp1_ready = 1'b1;
    step();
    check("bp_done_ready", 32'(req1_ready), 32'd1);

    // Contention: port 0 wins 4 cycles, then port 1 gets the starvation override
    drive1(1'b1, 32'h0000_00F0, 5'd4, ALU_SRL, 4'h5);
    for (int i = 0; i < 4; i++) begin
      drive0(1'b1, $urandom, 5'($urandom_range(0, 31)), ALU_SLLI);
      #1;
      check("cont_req0_ready", 32'(req0_ready), 32'd1);
      check("cont_req1_wait", 32'(req1_ready), 32'd0);
      step();
    end
    drive0(1'b1, 32'hDEAD_BEEF, 5'd7, ALU_SRAI);
    #1;
    check("starve_req1_ready", 32'(req1_ready), 32'd1);
    check("starve_req0_ready", 32'(req0_ready), 32'd0);
    step();
    // Counter restarted: one busy cycle plus four fresh starvation cycles before the next override
    for (int i = 0; i < 5; i++) begin
      drive0(1'b1, $urandom, 5'($urandom_range(0, 31)), ALU_SRAI);
      #1;
      check("restart_req1_wait", 32'(req1_ready), 32'd0);
      step();
    end
    #1;
    check("restart_req1_ready", 32'(req1_ready), 32'd1);
    step();
    drive0(1'b0, 32'h0, 5'd0, 5'd0);
    drive1(1'b0, 32'h0, 5'd0, 5'd0, 4'h0);
    step();
    step();

    // Port 1 parked in HOLD1 while port 0 streams three shifts
    rsp1_ready = 1'b0;
    drive1(1'b1, 32'h1234_5678, 5'd8, ALU_SRLI, 4'h3);
    step();
    drive1(1'b0, 32'h0, 5'd0, 5'd0, 4'h0);
    step();
    drive0(1'b1, 32'hF000_000F, 5'd0, ALU_SRA);
    step();
    drive0(1'b1, 32'hF000_000F, 5'd31, ALU_SRA);
    step();
    check("hold_r_stable", rsp1_r, 32'h0012_3456);
    drive0(1'b1, 32'hF000_000F, 5'd1, ALU_SLL);
    step();
    drive0(1'b0, 32'h0, 5'd0, 5'd0);
    step();
    check("hold_r_final", rsp1_r, 32'h0012_3456);
    check("hold_tag_final", 32'(rsp1_tag), 32'h3);
    rsp1_ready = 1'b1;
    step();

    // Unknown op code still produces a (zero) result
    drive0(1'b1, 32'hFFFF_FFFF, 5'd3, 5'h1F);
    step();
    check("unknown_valid", 32'(rsp0_valid), 32'd1);
    check("unknown_r", rsp0_r, 32'd0);
    drive0(1'b0, 32'h0, 5'd0, 5'd0);
    step();

    // Reset while a port 1 result is held
    rsp1_ready = 1'b0;
    drive1(1'b1, 32'h0000_0001, 5'd1, ALU_SLLI, 4'h7);
    step();
    drive1(1'b0, 32'h0, 5'd0, 5'd0, 4'h0);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid_rsp1_valid", 32'(rsp1_valid), 32'd0);
    check("rst_mid_req1_ready", 32'(req1_ready), 32'd1);
    step();
    check("rst_mid_idle", 32'(rsp1_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Shares the single combinational barrel shifter between two requesters.
  - Port 0: EX-stage ALU shift ops (SLL/SRL/SRA and immediate forms).
  - Port 1: the M-extension multiply/divide sequencer, which issues shift micro-ops.
- Registers the granted request into an operand stage that drives the shifter.
- Returns the result one cycle after acceptance. Port 1 results are buffered under backpressure.
- Starvation guard: port 1 is never locked out by back-to-back ALU shifts.

Parameters:
- STARVE_LIMIT, 4, consecutive cycles port 1 may wait with valid high before it overrides port 0 priority (legal range 1..15).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req0_valid  in  1  port 0 request
- req0_ready  out  1  port 0 accepted this cycle
- req0_a  in  32  port 0 operand
- req0_shamt  in  5  port 0 shift amount
- req0_type  in  5  port 0 ALU op code (ALU_SLL/SRL/SRA/SLLI/SRLI/SRAI)
- req1_valid  in  1  port 1 request
- req1_ready  out  1  port 1 accepted this cycle
- req1_a  in  32  port 1 operand
- req1_shamt  in  5  port 1 shift amount
- req1_type  in  5  port 1 ALU op code
- req1_tag  in  4  port 1 transaction tag, returned with result
- rsp0_valid  out  1  port 0 result valid (no backpressure)
- rsp0_r  out  32  port 0 result
- rsp1_valid  out  1  port 1 result valid
- rsp1_ready  in  1  port 1 consumer ready
- rsp1_r  out  32  port 1 result
- rsp1_tag  out  4  tag of port 1 result
- sh_a  out  32  to shifter operand
- sh_shamt  out  5  to shifter shamt
- sh_type  out  5  to shifter type
- sh_r  in  32  from shifter result

Behaviour:
- All state updates occur on the rising edge of clk.
- Reset (rst=1 at an edge) has priority over everything:
  - stage_v=0, owner=0, operand regs=0 (sh_type=0, so the shifter returns 0), state=IDLE, starve_cnt=0, hold regs=0.
  - An in-flight or held result is discarded.
  - Outputs after reset: rsp0_valid=0, rsp1_valid=0, req0_ready=1, req1_ready=1.
- Port 1 outstanding limit:
  - busy1 = (stage_v & owner==1) | (state==HOLD1).
  - Port 1 may have at most one op outstanding.
- Grant logic (combinational each cycle):
  - starve = (starve_cnt == STARVE_LIMIT).
  - grant1 = req1_valid & !busy1 & (!req0_valid | starve).
  - grant0 = req0_valid & !grant1.
  - req0_ready = !grant1.
  - req1_ready = !busy1 & (!req0_valid | starve).
- Accept / stage:
  - On grant, operands, type, tag and owner are latched; stage_v=1 the next cycle. Otherwise stage_v=0.
  - sh_a/sh_shamt/sh_type are driven directly from the stage regs.
  - Throughput: port 0 can issue every cycle; port 1 every other cycle at best.
- Response latency: exactly 1 cycle after acceptance.
  - rsp0_valid = stage_v & owner==0; rsp0_r = sh_r.
  - Port 1, state IDLE: rsp1_valid = stage_v & owner==1; rsp1_r = sh_r; rsp1_tag = stage tag.
  - If rsp1_valid & !rsp1_ready in IDLE: sh_r and tag are copied to the hold regs and the FSM moves to HOLD1.
- FSM:
  - IDLE -> HOLD1 on an unaccepted port 1 stage result.
  - HOLD1: rsp1_valid=1, rsp1_r/rsp1_tag come from the hold regs. HOLD1 -> IDLE when rsp1_ready=1.
  - Port 0 continues to issue and complete while in HOLD1.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) when req1_valid & !busy1 & !grant1.
  - Clears on grant1, or when req1_valid=0.
- Op codes: unknown types are passed through unchanged; the shifter returns 0 and the result is still delivered.
- Shift amount: shamt is 5 bits, so 0..31 only; no masking is performed here.

Test Plan:
- Reset mid-operation: port 1 result held in HOLD1, rst=1 for one cycle -> rsp1_valid=0 next cycle, state IDLE, req1_ready=1.
- Port 0 alone: req0 a=0x8000_0000, shamt=4, ALU_SRA -> next cycle rsp0_valid=1, rsp0_r=0xF800_0000. Repeat with ALU_SRL -> 0x0800_0000.
- Port 1 alone with backpressure: a=0x0000_0001, shamt=31, ALU_SLL, tag=0xA, rsp1_ready=0 for 3 cycles.
  - rsp1_valid stays 1, rsp1_r=0x8000_0000, tag=0xA stable.
  - req1_ready=0 throughout.
  - Completes the cycle rsp1_ready=1.
- Contention: req0 and req1 both valid continuously, STARVE_LIMIT=4.
  - Port 0 wins 4 cycles, then port 1 is granted on the 5th cycle.
  - req0_ready=0 that cycle; counter then returns to 0.
- Concurrency: port 1 in HOLD1 while port 0 issues 3 back-to-back shifts -> 3 correct rsp0 results on consecutive cycles; hold contents unchanged.
- Unknown type: req0_type=0x1F -> rsp0_valid=1, rsp0_r=0.
